// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : seg7_pkg
//  Description: Shared 7-segment constants and the hex font (active-low g..a).
//  Revision   : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [6:0] SEG_FONT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg7_font(input logic [3:0] nibble);
        return SEG_FONT[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module     : seg7_decoder
//  Description: Combinational nibble + decimal point to active-low segment code.
//  Revision   : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] hex_o
);

    assign hex_o = {~dp_i, seg7_font(nibble_i)};

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module     : seg7_scan_driver
//  Description: Time-multiplexed N-digit common-anode driver with guard
//               blanking, blink and frame-synchronous shadow updates.
//  Revision   : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_DIV      = 100000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   digit_en_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    input  logic                    upd_i,
    output logic                    frame_o,
    output logic [7:0]              HEX,
    output logic [NUM_DIGITS-1:0]   AN
);

    localparam int c_pc_w  = $clog2(CLK_DIV);
    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_bc_w  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int c_reg_w = 7 * NUM_DIGITS;

    localparam logic [c_pc_w-1:0]  c_pc_last  = c_pc_w'(CLK_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_bc_w-1:0]  c_bc_last  = c_bc_w'(BLINK_FRAMES - 1);

    logic [c_pc_w-1:0]     pc_q,          pc_d;
    logic [c_idx_w-1:0]    idx_q,         idx_d;
    logic [c_bc_w-1:0]     blink_cnt_q,   blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic                  pending_q,     pending_d;
    logic [c_reg_w-1:0]    shadow_q,      shadow_d;
    logic [c_reg_w-1:0]    active_q,      active_d;
    logic                  frame_q,       frame_d;
    logic [7:0]            hex_q,         hex_d;
    logic [NUM_DIGITS-1:0] an_q,          an_d;

    logic                    w_slot_end;
    logic                    w_frame_bnd;
    logic [4*NUM_DIGITS-1:0] w_act_digits;
    logic [NUM_DIGITS-1:0]   w_act_en;
    logic [NUM_DIGITS-1:0]   w_act_dp;
    logic [NUM_DIGITS-1:0]   w_act_blink;
    logic [3:0]              w_sel_nibble;
    logic                    w_sel_en;
    logic                    w_sel_dp;
    logic                    w_sel_blink;
    logic [7:0]              w_seg_code;
    logic                    w_blank;

    assign w_slot_end  = (pc_q == c_pc_last);
    assign w_frame_bnd = w_slot_end && (idx_q == c_idx_last);

    // Register layout is {digits, enable, dp, blink}, identical for shadow and active.
    assign w_act_digits = active_q[c_reg_w-1 -: 4*NUM_DIGITS];
    assign w_act_en     = active_q[3*NUM_DIGITS-1 -: NUM_DIGITS];
    assign w_act_dp     = active_q[2*NUM_DIGITS-1 -: NUM_DIGITS];
    assign w_act_blink  = active_q[NUM_DIGITS-1:0];

    always_comb begin
        pc_d          = w_slot_end ? '0 : pc_q + c_pc_w'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q;
        frame_d       = w_frame_bnd;

        if (w_slot_end) begin
            idx_d = (idx_q == c_idx_last) ? '0 : idx_q + c_idx_w'(1);
        end

        if (w_frame_bnd) begin
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
            if (blink_cnt_q == c_bc_last) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + c_bc_w'(1);
            end
        end

        // A strobe on the boundary cycle lands after the old shadow was applied.
        if (upd_i) begin
            shadow_d  = {digits_i, digit_en_i, dp_i, blink_i};
            pending_d = 1'b1;
        end
    end

    always_comb begin
        w_sel_nibble = '0;
        w_sel_en     = 1'b0;
        w_sel_dp     = 1'b0;
        w_sel_blink  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (int'(idx_q) == k) begin
                w_sel_nibble = w_act_digits[4*k +: 4];
                w_sel_en     = w_act_en[k];
                w_sel_dp     = w_act_dp[k];
                w_sel_blink  = w_act_blink[k];
            end
        end
    end

    seg7_decoder u_decoder (
        .nibble_i (w_sel_nibble),
        .dp_i     (w_sel_dp),
        .hex_o    (w_seg_code)
    );

    assign w_blank = (int'(pc_q) < GUARD) || !w_sel_en || (w_sel_blink && blink_phase_q);

    always_comb begin
        hex_d = SEG_BLANK;
        an_d  = '1;
        if (!w_blank) begin
            hex_d = w_seg_code;
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pending_q     <= 1'b0;
            shadow_q      <= '0;
            active_q      <= '0;
            frame_q       <= 1'b0;
            hex_q         <= SEG_BLANK;
            an_q          <= '1;
        end else begin
            pc_q          <= pc_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pending_q     <= pending_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            frame_q       <= frame_d;
            hex_q         <= hex_d;
            an_q          <= an_d;
        end
    end

    assign frame_o = frame_q;
    assign HEX     = hex_q;
    assign AN      = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module     : tb_seg7_scan_driver
//  Description: Randomized self-checking bench against a time-based display model.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int c_n     = 4;
    localparam int c_div   = 8;
    localparam int c_guard = 2;
    localparam int c_bf    = 2;
    localparam int c_frame = c_n * c_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_i;
    logic [3:0]  digit_en_i;
    logic [3:0]  dp_i;
    logic [3:0]  blink_i;
    logic        upd_i;
    logic        frame_o;
    logic [7:0]  HEX;
    logic [3:0]  AN;

    int k;
    int err_cnt;
    int chk_cnt;
    int          upd_edge[$];
    logic [27:0] upd_data[$];

    logic [7:0] font_tbl [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg7_scan_driver #(
        .NUM_DIGITS   (c_n),
        .CLK_DIV      (c_div),
        .GUARD        (c_guard),
        .BLINK_FRAMES (c_bf)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_i   (digits_i),
        .digit_en_i (digit_en_i),
        .dp_i       (dp_i),
        .blink_i    (blink_i),
        .upd_i      (upd_i),
        .frame_o    (frame_o),
        .HEX        (HEX),
        .AN         (AN)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, k);
        end
    endtask

    // k edges since reset release. After edge k the outputs show the scan position of
    // edge k-1; data shown is the last update sampled strictly before the latest frame wrap.
    task automatic model(output logic [7:0] eh, output logic [3:0] ea, output logic ef);
        int n, p, i, nb, mb;
        logic [27:0] act;
        logic ph;
        eh = 8'hFF;
        ea = 4'hF;
        ef = 1'b0;
        if (!rst_n || k == 0) return;
        ef  = (k % c_frame) == 0;
        n   = k - 1;
        p   = n % c_div;
        i   = (n / c_div) % c_n;
        nb  = n / c_frame;
        mb  = nb * c_frame;
        act = '0;
        for (int j = 0; j < upd_edge.size(); j++)
            if (nb > 0 && upd_edge[j] < mb) act = upd_data[j];
        ph = ((nb / c_bf) % 2) == 1;
        if (p < c_guard) return;
        if (!act[8 + i]) return;
        if (act[i] && ph) return;
        ea = ~(4'b0001 << i);
        eh = font_tbl[act[12 + 4*i +: 4]];
        if (act[4 + i]) eh[7] = 1'b0;
    endtask

    task automatic check_outputs();
        logic [7:0] eh;
        logic [3:0] ea;
        logic       ef;
        model(eh, ea, ef);
        check_value("HEX", 32'(HEX), 32'(eh));
        check_value("AN", 32'(AN), 32'(ea));
        check_value("frame_o", 32'(frame_o), 32'(ef));
    endtask

    task automatic tick();
        @(posedge clk);
        k = rst_n ? k + 1 : 0;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int cycles);
        repeat (cycles) tick();
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp,
                        input logic [3:0] bl);
        logic [31:0] junk;
        upd_edge.push_back(k + 1);
        upd_data.push_back({d, en, dp, bl});
        digits_i   = d;
        digit_en_i = en;
        dp_i       = dp;
        blink_i    = bl;
        upd_i      = 1'b1;
        tick();
        upd_i      = 1'b0;
        junk       = $urandom();
        digits_i   = junk[15:0];
        digit_en_i = junk[19:16];
        dp_i       = junk[23:20];
        blink_i    = junk[27:24];
    endtask

    task automatic wait_phase(input int r);
        for (int g = 0; g < c_frame && (k % c_frame) != r; g++) tick();
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        err_cnt    = 0;
        chk_cnt    = 0;
        k          = 0;
        upd_i      = 1'b0;
        digits_i   = '0;
        digit_en_i = '0;
        dp_i       = '0;
        blink_i    = '0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;

        run(3);
        rst_n = 1'b1;
        run(70);

        send(16'h3210, 4'hF, 4'h0, 4'h0);
        run(80);

        send(16'hFEDC, 4'b0101, 4'b0001, 4'h0);
        run(70);

        wait_phase(10);
        send(16'h9999, 4'hF, 4'h0, 4'h0);
        run(60);

        wait_phase(c_frame - 1);
        send(16'h4567, 4'hF, 4'b1010, 4'h0);
        run(70);

        send(16'hABCD, 4'hF, 4'h0, 4'b0010);
        run(200);

        repeat (8) begin
            r1 = $urandom();
            r2 = $urandom();
            run($urandom_range(0, 40));
            send(r1[15:0], r2[3:0], r2[7:4], r2[11:8]);
        end
        run(100);

        send(16'h1234, 4'hF, 4'h0, 4'h0);
        run(70);
        wait_phase(21);
        rst_n = 1'b0;
        upd_edge.delete();
        upd_data.delete();
        k = 0;
        #1 check_outputs();
        run(2);
        rst_n = 1'b1;
        run(70);
        send(16'h8765, 4'hF, 4'h0, 4'h0);
        run(70);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
